// File: rtl/data_sram_ctrl_if.sv
// Bundle of the EXE request, MEM response and split-transaction SRAM bus signals
// that pass through the data-SRAM access controller.
interface data_sram_ctrl_if;
  logic        exe_req_valid;
  logic        exe_req_wr;
  logic [1:0]  exe_req_size;
  logic [31:0] exe_req_addr;
  logic [3:0]  exe_req_wstrb;
  logic [31:0] exe_req_wdata;
  logic        exe_req_accept;
  logic        flush;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_ready;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  // Pipeline/SRAM environment side.
  modport master (
    output exe_req_valid, exe_req_wr, exe_req_size, exe_req_addr, exe_req_wstrb, exe_req_wdata,
    output flush, mem_resp_ready, data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  exe_req_accept, mem_resp_valid, mem_resp_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb,
    input  data_sram_wdata
  );

  // Controller side.
  modport slave (
    input  exe_req_valid, exe_req_wr, exe_req_size, exe_req_addr, exe_req_wstrb, exe_req_wdata,
    input  flush, mem_resp_ready, data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output exe_req_accept, mem_resp_valid, mem_resp_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb,
    output data_sram_wdata
  );
endinterface

// File: rtl/data_sram_ctrl.sv
// Data-SRAM access controller: issues EXE requests on a req/addr_ok bus, tracks in-order
// outstanding transactions, buffers data_ok responses for MEM and drops flushed ones.
module data_sram_ctrl #(
  parameter int unsigned MAX_OUT = 2
) (
  input logic             clk,
  input logic             resetn,
  data_sram_ctrl_if.slave bus
);
  localparam int unsigned   CntW    = $clog2(MAX_OUT + 1);
  localparam int unsigned   PtrW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CntW:0] FullVal = (CntW + 1)'(MAX_OUT);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUT - 1);

  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] disc_cnt_q, disc_cnt_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_q [MAX_OUT];
  logic [31:0]     fifo_d [MAX_OUT];

  logic full, accept, dok, dropping, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) == FullVal;
  assign dok      = bus.data_sram_data_ok;
  assign dropping = disc_cnt_q != '0;
  assign accept   = bus.data_sram_req & bus.data_sram_addr_ok;
  assign push     = dok & ~dropping & ~bus.flush;
  assign pop      = bus.mem_resp_valid & bus.mem_resp_ready & ~bus.flush;

  assign bus.data_sram_req   = resetn & bus.exe_req_valid & ~full & ~bus.flush;
  assign bus.data_sram_wr    = bus.exe_req_wr;
  assign bus.data_sram_size  = bus.exe_req_size;
  assign bus.data_sram_addr  = bus.exe_req_addr;
  assign bus.data_sram_wstrb = bus.exe_req_wstrb;
  assign bus.data_sram_wdata = bus.exe_req_wdata;
  assign bus.exe_req_accept  = accept;
  assign bus.mem_resp_valid  = fifo_cnt_q != '0;
  assign bus.mem_resp_rdata  = fifo_q[rd_ptr_q];

  always_comb begin
    out_cnt_d  = out_cnt_q + CntW'(accept) - CntW'(dok);
    disc_cnt_d = disc_cnt_q - CntW'(dok & dropping);
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fifo_d     = fifo_q;
    if (push) fifo_d[wr_ptr_q] = bus.data_sram_rdata;
    if (bus.flush) begin
      // Every still-outstanding transaction becomes a discard; already-discarded ones are
      // part of out_cnt too, and a data_ok in this cycle retires one of them either way.
      disc_cnt_d = out_cnt_q - CntW'(dok);
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is carried by fifo_cnt_q.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: table-driven vectors plus hand sequences, with a
// response scoreboard fed when data_ok is driven and drained when MEM pops.
module tb_data_sram_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  data_sram_ctrl_if bus ();
  data_sram_ctrl_if bus3 ();

  data_sram_ctrl #(.MAX_OUT(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  data_sram_ctrl #(.MAX_OUT(3)) dut3 (.clk(clk), .resetn(resetn), .bus(bus3));

  int n_cmp = 0;
  int n_err = 0;
  int tb_out = 0;
  logic [31:0] exp_q [$];
  logic o_req, o_acc, o_rv;
  logic [31:0] o_rd;

  typedef struct {
    logic v; logic [31:0] addr; logic aok; logic dok; logic [31:0] rd; logic rdy;
    logic e_req; logic e_acc; logic e_rv; logic [31:0] e_rd;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle on the MAX_OUT=2 DUT; outputs are sampled before the edge.
  task automatic cycle(input logic v, input logic wr, input logic [31:0] addr, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic rdy, input logic fl,
                       input logic keep, input logic rstn, output logic req, output logic acc,
                       output logic rv, output logic [31:0] rdat);
    bus.exe_req_valid = v;       bus.exe_req_wr = wr;         bus.exe_req_size = 2'd2;
    bus.exe_req_addr = addr;     bus.exe_req_wstrb = 4'hf;    bus.exe_req_wdata = addr ^ 32'h5a5a5a5a;
    bus.data_sram_addr_ok = aok; bus.data_sram_data_ok = dok; bus.data_sram_rdata = rd;
    bus.mem_resp_ready = rdy;    bus.flush = fl;              resetn = rstn;
    #1;
    req = bus.data_sram_req; acc = bus.exe_req_accept;
    rv = bus.mem_resp_valid; rdat = bus.mem_resp_rdata;
    if (rstn && dok) chk("data_ok_with_outstanding", 32'(tb_out > 0), 32'd1);
    if (req) begin
      chk("addr_passthrough", bus.data_sram_addr, addr);
      chk("wdata_passthrough", bus.data_sram_wdata, addr ^ 32'h5a5a5a5a);
    end
    if (rstn && !fl && rv && rdy) begin
      if (exp_q.size() == 0) chk("unexpected_resp", rdat, 32'hxxxxxxxx);
      else chk("scoreboard_rdata", rdat, exp_q.pop_front());
    end
    if (!rstn) begin
      exp_q.delete();
      tb_out = 0;
    end else begin
      if (fl) exp_q.delete();
      tb_out = tb_out + int'(acc) - int'(dok);
      if (dok && keep && !fl) exp_q.push_back(rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic req, output logic acc, output logic rv, output logic [31:0] r);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, req, acc, rv, r);
  endtask

  task automatic drive3(input logic v, input logic aok, input logic dok, input logic [31:0] rd,
                        input logic rdy);
    bus3.exe_req_valid = v;       bus3.exe_req_addr = 32'h4000; bus3.data_sram_addr_ok = aok;
    bus3.data_sram_data_ok = dok; bus3.data_sram_rdata = rd;    bus3.mem_resp_ready = rdy;
    #1;
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus3.exe_req_wr = 0; bus3.exe_req_size = 2'd2; bus3.exe_req_wstrb = 4'hf;
    bus3.exe_req_wdata = 0; bus3.flush = 0;
    drive3(0, 0, 0, 0, 0);
    // Single load, then a load whose addr_ok is held off for three cycles.
    vecs[0]  = '{1, 32'h1000, 1, 0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF};
    vecs[4]  = '{0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF};
    vecs[5]  = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 32'h2000, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{1, 32'h2000, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{1, 32'h2000, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{1, 32'h2000, 1, 0, 0, 0, 1, 1, 0, 0};
    vecs[10] = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 32'h0, 0, 1, 32'hCAFE0001, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 32'hCAFE0001};
    vecs[13] = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset with a request pending: nothing may be issued.
    cycle(1, 0, 32'h10, 1, 0, 0, 0, 0, 0, 0, o_req, o_acc, o_rv, o_rd);
    chk("rst_req", 32'(o_req), 0);
    chk("rst_acc", 32'(o_acc), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o_req, o_acc, o_rv, o_rd);
    idle(o_req, o_acc, o_rv, o_rd);
    chk("rst_resp_valid", 32'(o_rv), 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].v, 0, vecs[i].addr, vecs[i].aok, vecs[i].dok, vecs[i].rd, vecs[i].rdy, 0, 1, 1,
            o_req, o_acc, o_rv, o_rd);
      chk($sformatf("vec%0d_req", i), 32'(o_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d_acc", i), 32'(o_acc), 32'(vecs[i].e_acc));
      chk($sformatf("vec%0d_rv", i), 32'(o_rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d_rd", i), o_rd, vecs[i].e_rd);
    end

    // Back-pressure at MAX_OUT=2.
    cycle(1, 0, 32'h100, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_acc0", 32'(o_acc), 1);
    cycle(1, 1, 32'h104, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_acc1", 32'(o_acc), 1);
    cycle(1, 0, 32'h108, 1, 1, 32'h11, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_full0", 32'(o_req), 0);
    cycle(1, 0, 32'h108, 1, 1, 32'h22, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_full1", 32'(o_req), 0);
    cycle(1, 0, 32'h108, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_full2", 32'(o_req), 0);
    chk("bp_head", o_rd, 32'h11);
    cycle(1, 0, 32'h108, 0, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_full3", 32'(o_req), 0);
    cycle(1, 0, 32'h108, 0, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("bp_reenable", 32'(o_req), 1);
    chk("bp_head2", o_rd, 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd);
    idle(o_req, o_acc, o_rv, o_rd); chk("bp_empty", 32'(o_rv), 0);

    // Flush with one outstanding and one buffered response.
    cycle(1, 0, 32'h200, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_acc0", 32'(o_acc), 1);
    cycle(1, 0, 32'h204, 1, 1, 32'h33, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_acc1", 32'(o_acc), 1);
    cycle(1, 0, 32'h208, 1, 0, 0, 1, 1, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_block", 32'(o_req), 0);
    cycle(0, 0, 0, 0, 1, 32'h44, 1, 0, 0, 1, o_req, o_acc, o_rv, o_rd); chk("fl_rv0", 32'(o_rv), 0);
    cycle(1, 0, 32'h20c, 1, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_rv1", 32'(o_rv), 0);
    chk("fl_acc2", 32'(o_acc), 1);
    cycle(0, 0, 0, 0, 1, 32'h66, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_rv2", 32'(o_rv), 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fl_new_rv", 32'(o_rv), 1);
    idle(o_req, o_acc, o_rv, o_rd); chk("fl_empty", 32'(o_rv), 0);

    // Flush in the same cycle as data_ok with nothing pending discard.
    cycle(1, 0, 32'h500, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fd_acc0", 32'(o_acc), 1);
    cycle(1, 0, 32'h504, 1, 1, 32'h77, 1, 1, 0, 1, o_req, o_acc, o_rv, o_rd); chk("fd_acc_blk", 32'(o_acc), 0);
    cycle(1, 0, 32'h508, 1, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fd_rv", 32'(o_rv), 0);
    chk("fd_acc1", 32'(o_acc), 1);
    cycle(1, 0, 32'h50c, 1, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fd_acc2", 32'(o_acc), 1);
    cycle(0, 0, 0, 0, 1, 32'h88, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd);
    cycle(0, 0, 0, 0, 1, 32'h99, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("fd_kept", 32'(o_rv), 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd);
    idle(o_req, o_acc, o_rv, o_rd); chk("fd_empty", 32'(o_rv), 0);

    // Reset asserted with one outstanding and one buffered.
    cycle(1, 0, 32'h300, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("rm_acc0", 32'(o_acc), 1);
    cycle(1, 0, 32'h304, 1, 1, 32'hAA, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("rm_acc1", 32'(o_acc), 1);
    cycle(1, 0, 32'h308, 1, 0, 0, 0, 0, 1, 0, o_req, o_acc, o_rv, o_rd); chk("rm_req_in_rst", 32'(o_req), 0);
    idle(o_req, o_acc, o_rv, o_rd);
    chk("rm_rv", 32'(o_rv), 0);
    chk("rm_req", 32'(o_req), 0);
    chk("rm_acc", 32'(o_acc), 0);
    cycle(1, 0, 32'h30c, 1, 0, 0, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("rm_acc2", 32'(o_acc), 1);
    cycle(0, 0, 0, 0, 1, 32'hBB, 0, 0, 1, 1, o_req, o_acc, o_rv, o_rd);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, o_req, o_acc, o_rv, o_rd); chk("rm_new_rv", 32'(o_rv), 1);
    idle(o_req, o_acc, o_rv, o_rd); chk("rm_empty", 32'(o_rv), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    // MAX_OUT=3: accept, data_ok and pop together while the FIFO holds one entry.
    drive3(1, 1, 0, 0, 0);          chk("s3_acc0", 32'(bus3.exe_req_accept), 1); step3();
    drive3(0, 0, 1, 32'hA1, 0);     step3();
    drive3(1, 1, 0, 0, 0);          chk("s3_acc1", 32'(bus3.exe_req_accept), 1);
    chk("s3_head0", bus3.mem_resp_rdata, 32'hA1); step3();
    drive3(1, 1, 1, 32'hA2, 1);     chk("s3_acc2", 32'(bus3.exe_req_accept), 1);
    chk("s3_rv0", 32'(bus3.mem_resp_valid), 1);
    chk("s3_pop0", bus3.mem_resp_rdata, 32'hA1); step3();
    drive3(1, 0, 0, 0, 0);          chk("s3_req_room", 32'(bus3.data_sram_req), 1);
    chk("s3_head1", bus3.mem_resp_rdata, 32'hA2); step3();
    drive3(0, 0, 1, 32'hA3, 1);     chk("s3_pop1", bus3.mem_resp_rdata, 32'hA2); step3();
    drive3(0, 0, 0, 0, 1);          chk("s3_rv1", 32'(bus3.mem_resp_valid), 1);
    chk("s3_pop2", bus3.mem_resp_rdata, 32'hA3); step3();
    drive3(0, 0, 0, 0, 0);          chk("s3_empty", 32'(bus3.mem_resp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
